// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: rebuilds pixel coordinates, active-video and lock status from a VGA hsync/vsync/rgb stream
// Inputs : clk, reset (async, active-low), pix_tick (pixel-rate enable), hsync/vsync (active-low), rgb_in[2:0]
// Outputs: dec_x/dec_y (active coordinates, 0 outside), dec_video_on, dec_rgb (blanked outside active),
//          locked, frame_start/line_err/frame_err (one-clk pulses)
// Option : FRAME_SUM_EN adds frame_sum[23:0], the sum of rgb_in over the active pixels of the previous frame
module vga_sync_decoder #(
    parameter int H_ACTIVE = 640,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int H_TOTAL  = 800,
    parameter int V_ACTIVE = 480,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int V_TOTAL  = 525
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_tick,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [2:0]  rgb_in,
    output logic [9:0]  dec_x,
    output logic [9:0]  dec_y,
    output logic        dec_video_on,
    output logic [2:0]  dec_rgb,
    output logic        locked,
    output logic        frame_start,
    output logic        line_err,
`ifdef FRAME_SUM_EN
    output logic [23:0] frame_sum,
`endif
    output logic        frame_err
);
    localparam int H_START = H_SYNC + H_BP;
    localparam int V_START = V_SYNC + V_BP;

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;
    state_t state, state_nx;
    logic hs_d, vs_d, frame_good, frame_good_nx, line_err_nx, frame_err_nx;
    logic hs_fall, vs_fall, line_bad, frame_bad, active;
    logic [9:0] hcnt, vline, hcnt_nx, vline_nx;

    // Counter values are those of the sample being taken, so outputs describe that sample one clk later
    always_comb begin
        hs_fall   = pix_tick && !hsync && hs_d;
        vs_fall   = pix_tick && !vsync && vs_d;
        hcnt_nx   = hs_fall ? 10'd0 : (hcnt == 10'd1023 ? hcnt : hcnt + 10'd1);
        vline_nx  = vs_fall ? 10'd0 : (hs_fall && vline != 10'd1023) ? vline + 10'd1 : vline;
        line_bad  = hs_fall && ({1'b0, hcnt} + 11'd1 != 11'(H_TOTAL));
        frame_bad = vs_fall && ({1'b0, vline} + 11'd1 != 11'(V_TOTAL));
        active    = hcnt_nx >= 10'(H_START) && hcnt_nx < 10'(H_START + H_ACTIVE) &&
                    vline_nx >= 10'(V_START) && vline_nx < 10'(V_START + V_ACTIVE);
    end

    always_comb begin
        state_nx      = state;
        frame_good_nx = frame_good;
        line_err_nx   = 1'b0;
        frame_err_nx  = 1'b0;
        if (pix_tick) begin
            // A saturated line counter means hsync has gone away: drop back to acquisition silently
            if (hcnt_nx == 10'd1023)
                state_nx = SEARCH;
            else if (state == SEARCH) begin
                if (vs_fall) begin
                    state_nx      = MEASURE;
                    frame_good_nx = 1'b1;
                end
            end else begin
                line_err_nx  = line_bad;
                frame_err_nx = frame_bad;
                if (state == MEASURE) begin
                    if (line_bad)
                        frame_good_nx = 1'b0;
                    if (vs_fall) begin
                        state_nx      = (frame_good && !line_bad && !frame_bad) ? LOCKED : MEASURE;
                        frame_good_nx = 1'b1;
                    end
                end else if (line_bad || frame_bad) begin
                    state_nx      = MEASURE;
                    // A bad line taints the frame it sits in, unless a new frame starts right here
                    frame_good_nx = vs_fall || !line_bad;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= SEARCH;
            frame_good   <= 1'b0;
            hs_d         <= 1'b1;
            vs_d         <= 1'b1;
            hcnt         <= '0;
            vline        <= '0;
            dec_x        <= '0;
            dec_y        <= '0;
            dec_video_on <= 1'b0;
            dec_rgb      <= '0;
            frame_start  <= 1'b0;
            line_err     <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            state       <= state_nx;
            frame_good  <= frame_good_nx;
            frame_start <= vs_fall;
            line_err    <= line_err_nx;
            frame_err   <= frame_err_nx;
            if (pix_tick) begin
                hs_d         <= hsync;
                vs_d         <= vsync;
                hcnt         <= hcnt_nx;
                vline        <= vline_nx;
                dec_video_on <= active;
                dec_x        <= active ? hcnt_nx - 10'(H_START) : 10'd0;
                dec_y        <= active ? vline_nx - 10'(V_START) : 10'd0;
                dec_rgb      <= active ? rgb_in : 3'd0;
            end
        end
    end

    assign locked = (state == LOCKED);

`ifdef FRAME_SUM_EN
    logic [23:0] sum_acc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum_acc   <= '0;
            frame_sum <= '0;
        end else if (vs_fall) begin
            sum_acc   <= '0;
            frame_sum <= sum_acc;
        end else if (pix_tick && active)
            sum_acc <= sum_acc + 24'(rgb_in);
    end
`endif
endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: drives synthetic VGA streams into a reduced-geometry and a default-geometry decoder
module tb_vga_sync_decoder;
    logic       clk = 1'b0, reset = 1'b1, pix_tick = 1'b0, hsync = 1'b1, vsync = 1'b1;
    logic [2:0] rgb_in = '0;
    logic [9:0] d_x, d_y, e_x, e_y;
    logic [2:0] d_rgb, e_rgb;
    logic       d_von, d_lock, d_fs, d_le, d_fe;
    logic       e_von, e_lock, e_fs, e_le, e_fe;
`ifdef FRAME_SUM_EN
    logic [23:0] d_sum, e_sum;
`endif
    int total = 0, bad = 0;
    int mode = 0, gapmax = 3;
    int hs_w, hstart, hact, htot, vs_w, vstart, vact;
    int sum_acc = 0;
    logic lock_now = 1'b0;

    always #5 clk = ~clk;

    vga_sync_decoder #(
        .H_ACTIVE(10), .H_SYNC(4), .H_BP(3), .H_TOTAL(20),
        .V_ACTIVE(5), .V_SYNC(2), .V_BP(2), .V_TOTAL(12)
    ) u_dut (
        .clk(clk), .reset(reset), .pix_tick(pix_tick), .hsync(hsync), .vsync(vsync), .rgb_in(rgb_in),
        .dec_x(d_x), .dec_y(d_y), .dec_video_on(d_von), .dec_rgb(d_rgb), .locked(d_lock),
        .frame_start(d_fs), .line_err(d_le),
`ifdef FRAME_SUM_EN
        .frame_sum(d_sum),
`endif
        .frame_err(d_fe)
    );

    vga_sync_decoder u_def (
        .clk(clk), .reset(reset), .pix_tick(pix_tick), .hsync(hsync), .vsync(vsync), .rgb_in(rgb_in),
        .dec_x(e_x), .dec_y(e_y), .dec_video_on(e_von), .dec_rgb(e_rgb), .locked(e_lock),
        .frame_start(e_fs), .line_err(e_le),
`ifdef FRAME_SUM_EN
        .frame_sum(e_sum),
`endif
        .frame_err(e_fe)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_tick(input logic hs, input logic vs, input logic [2:0] rgb);
        hsync = hs;
        vsync = vs;
        rgb_in = rgb;
        pix_tick = 1'b1;
        @(negedge clk);
        pix_tick = 1'b0;
    endtask

    task automatic idle();
        repeat ($urandom_range(0, gapmax)) begin
            @(negedge clk);
            chk("pulse_width", {29'd0, d_fs, d_le, d_fe}, 32'd0);
        end
    endtask

    // Expected outputs straight from the stream position (h ticks into line v of the frame)
    task automatic check_px(input int h, input int v, input logic [2:0] rgb, input logic fs, input logic le, input logic fe);
        logic act;
        act = h >= hstart && h < hstart + hact && v >= vstart && v < vstart + vact;
        chk("video_on", mode != 0 ? e_von : d_von, act);
        chk("dec_x", mode != 0 ? e_x : d_x, act ? h - hstart : 0);
        chk("dec_y", mode != 0 ? e_y : d_y, act ? v - vstart : 0);
        chk("dec_rgb", mode != 0 ? e_rgb : d_rgb, act ? rgb : 3'd0);
        chk("frame_start", mode != 0 ? e_fs : d_fs, fs);
        chk("line_err", mode != 0 ? e_le : d_le, le);
        chk("frame_err", mode != 0 ? e_fe : d_fe, fe);
        chk("locked", mode != 0 ? e_lock : d_lock, lock_now);
        if (act && mode == 0)
            sum_acc += int'(rgb);
    endtask

    // nlines lines of htot ticks (line short_idx one tick short); cut >= 0 stops after that many ticks
    task automatic send_frame(input int nlines, input int short_idx, input logic exp_lock, input logic exp_fe, input int cut);
        int sent;
        logic [2:0] rgb;
        logic le, first;
        sent = 0;
        for (int v = 0; v < nlines; v++)
            for (int h = 0; h < (v == short_idx ? htot - 1 : htot); h++) begin
                if (sent == cut)
                    return;
                sent++;
                rgb = (mode != 0 && v == 35 && h == 144) ? 3'b101 : 3'($urandom);
                do_tick(h >= hs_w, v >= vs_w, rgb);
                first = (h == 0 && v == 0);
                le = short_idx >= 0 && v == short_idx + 1 && h == 0;
                if (first)
                    lock_now = exp_lock;
                if (le)
                    lock_now = 1'b0;
`ifdef FRAME_SUM_EN
                if (first && mode == 0) begin
                    chk("frame_sum", d_sum, sum_acc);
                    sum_acc = 0;
                end
`endif
                check_px(h, v, rgb, first, le, first && exp_fe);
                idle();
            end
    endtask

    // hsync lost: the line counter runs on from htot and lock drops once it pins at 1023
    task automatic hold_high(input int n);
        for (int i = 0; i < n; i++) begin
            do_tick(1'b1, 1'b1, 3'($urandom));
            lock_now = lock_now && (htot + i < 1023);
            check_px(2000, 0, 3'd0, 1'b0, 1'b0, 1'b0);
            idle();
        end
    endtask

    initial begin
        hs_w = 4; hstart = 7; hact = 10; htot = 20;
        vs_w = 2; vstart = 4; vact = 5;
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_dec_x", d_x, 0);
        chk("rst_dec_y", d_y, 0);
        chk("rst_video_on", d_von, 0);
        chk("rst_dec_rgb", d_rgb, 0);
        chk("rst_locked", d_lock, 0);
        chk("rst_pulses", {29'd0, d_fs, d_le, d_fe}, 0);
        reset = 1'b1;
        @(negedge clk);
        send_frame(12, -1, 1'b0, 1'b0, -1);
        send_frame(12, -1, 1'b1, 1'b0, -1);
        send_frame(12, -1, 1'b1, 1'b0, -1);
        send_frame(12, -1, 1'b1, 1'b0, -1);
        send_frame(12, int'($urandom_range(0, 10)), 1'b1, 1'b0, -1);
        send_frame(12, -1, 1'b0, 1'b0, -1);
        send_frame(12, -1, 1'b1, 1'b0, -1);
        send_frame(11, -1, 1'b1, 1'b0, -1);
        send_frame(12, -1, 1'b0, 1'b1, -1);
        send_frame(12, -1, 1'b1, 1'b0, -1);
        hold_high(1024);
        send_frame(12, -1, 1'b0, 1'b0, -1);
        send_frame(12, -1, 1'b1, 1'b0, -1);
        send_frame(12, -1, 1'b1, 1'b0, 110);
        #2 reset = 1'b0;
        #1;
        chk("async_locked", d_lock, 0);
        chk("async_video_on", d_von, 0);
        chk("async_dec_x", d_x, 0);
        chk("async_dec_y", d_y, 0);
        chk("async_dec_rgb", d_rgb, 0);
        sum_acc = 0;
        @(negedge clk);
        reset = 1'b1;
        send_frame(12, -1, 1'b0, 1'b0, -1);
        send_frame(12, -1, 1'b1, 1'b0, -1);
        mode = 1; gapmax = 0;
        hs_w = 96; hstart = 144; hact = 640; htot = 800;
        vs_w = 2; vstart = 35; vact = 480;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        send_frame(37, -1, 1'b0, 1'b0, -1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
